dense_accum: RTL and testbench
==============================

DENSE_ACCUM -- requirements
Module: dense_accum

Interface
REQ-001 Parameter DATA_W, default 16: signed fixed-point width of activations, weights, bias and result.
REQ-002 Parameter LANES, default 9: element pairs consumed per input beat.
REQ-003 Parameter ACC_W, default 40: signed accumulator width; must be at least 2*DATA_W+$clog2(LANES)+4, with an elaboration-time check.
REQ-004 Parameter FRAC, default 8: fractional bits of the data format.
REQ-005 Parameter LEN_W, default 16: width of the vector-length field.
REQ-006 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: begin a dot product; sampled only in IDLE.
REQ-009 Port cfg_len, input, LEN_W: element count N of the vector, sampled with start.
REQ-010 Port bias, input, DATA_W: signed bias, sampled with start.
REQ-011 Port relu_en, input, 1: clamp negative results to zero, sampled with start.
REQ-012 Port in_valid, input, 1: in_data and in_wgt hold a beat.
REQ-013 Port in_ready, output, 1: the block accepts a beat this cycle.
REQ-014 Port in_data, input, LANES*DATA_W: packed signed activations, lane 0 in the LSBs.
REQ-015 Port in_wgt, input, LANES*DATA_W: packed signed weights, lane 0 in the LSBs.
REQ-016 Port out_valid, output, 1: result available.
REQ-017 Port out_ready, input, 1: consumer accepts the result.
REQ-018 Port out_data, output, DATA_W: saturated, optionally ReLU'd result.
REQ-019 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, DRAIN and OUT.
REQ-021 Transitions: IDLE to RUN on start with N>0; IDLE to OUT on start with N=0; RUN to DRAIN when the final beat is accepted; DRAIN to OUT when the final product has been accumulated; OUT to IDLE on out_valid&&out_ready.
REQ-022 On start, the block SHALL load acc=sign_extend(bias)<<FRAC, rem=N, and latch relu_en.
REQ-023 in_ready SHALL equal (state==RUN && rem>0), with no combinational dependence on in_valid.
REQ-024 A beat is accepted on in_valid&&in_ready, and the block SHALL then set rem = rem - min(rem, LANES).
REQ-025 Lane i is active iff i < rem, evaluated before the decrement; an inactive lane's weight SHALL be forced to 0 before multiplication.
REQ-026 Pipeline stage S1 SHALL register the full-precision sum of LANES signed DATA_W x DATA_W products, together with a valid bit.
REQ-027 Stage S2 SHALL add the sign-extended S1 sum into acc on the cycle after acceptance.
REQ-028 Latency: a final beat accepted at edge E0 SHALL give out_valid=1 after edge E0+2.
REQ-029 Back-to-back beats SHALL be accepted every cycle at full rate; the S1/S2 path has no stalls.
REQ-030 Result: r = acc >>> FRAC (arithmetic shift, truncation toward minus infinity).
REQ-031 out_data SHALL be 2^(DATA_W-1)-1 if r exceeds it, -2^(DATA_W-1) if r is below it, and r otherwise.
REQ-032 When relu_en is latched and the saturated value is negative, out_data SHALL be 0.
REQ-033 In OUT, out_valid and out_data SHALL stay stable until out_ready; in_ready stays 0.
REQ-034 start SHALL be ignored in every state other than IDLE, including the out-handshake cycle.
REQ-035 For N=0, out_valid SHALL rise one cycle after start with out_data = saturated bias, ReLU applied if enabled.
REQ-036 in_data and in_wgt SHALL be don't-care when in_ready=0 or in_valid=0.

Reset
REQ-037 On rst, the block SHALL clear state to IDLE, and acc, rem, the S1 sum, S1 valid and latched relu_en to 0.
REQ-038 After reset, in_ready=0, out_valid=0, out_data=0 and busy=0.
REQ-039 rst SHALL take priority over all other inputs; a job in progress is discarded and produces no result.

Structure
REQ-040 Package dense_pkg SHALL hold the state enum, default parameter constants and a saturate/ReLU function shared with sibling blocks.
REQ-041 A single sub-module, dense_mac_tree, SHALL hold lane masking, the LANES multipliers, the adder tree and the S1 register.
REQ-042 The FSM, rem counter, accumulator and output logic SHALL reside in dense_accum.

Verification (DATA_W=16, FRAC=8, LANES=9)
REQ-043 N=9, all data and weights 0x0100, bias 0 -> out_data 0x0900, with out_valid 2 cycles after the beat.
REQ-044 N=20, three beats, data and weights 0x0100, lanes 2-8 of the last beat carrying 0x7FFF -> out_data 0x1400.
REQ-045 N=9, data 0x7FFF, weights 0x7FFF -> 0x7FFF; weights 0x8001 -> 0x8000; the same with relu_en=1 -> 0x0000.
REQ-046 N=0, bias 0x0180 -> out_data 0x0180 one cycle after start; N=0, bias 0xFF00 with relu_en=1 -> 0x0000.
REQ-047 out_ready held low for 5 cycles in OUT, with start pulsed -> out_data held, in_ready=0, start ignored, busy=1.
REQ-048 rst asserted after 1 of 3 beats -> no out_valid; an immediately following N=9 job returns the correct 0x0900.

Source files
------------

// File: rtl/dense_pkg.sv
// ---------------------------------------------------------------------------
// dense_pkg
// Shared definitions for the dense dot-product accumulator family:
//   - default parameter constants
//   - FSM state enumeration
//   - sat_relu(): saturate a wide signed result to data_w bits, then
//     optionally clamp negatives to zero (shared with sibling blocks)
// ---------------------------------------------------------------------------
package dense_pkg;

  localparam int DENSE_DATA_W = 16;
  localparam int DENSE_LANES  = 9;
  localparam int DENSE_ACC_W  = 40;
  localparam int DENSE_FRAC   = 8;
  localparam int DENSE_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } dense_state_e;

  // Clamp r into [-2^(data_w-1), 2^(data_w-1)-1]; zero negatives when relu.
  // Works on a 64-bit container so any accumulator up to 64 bits fits.
  function automatic logic signed [63:0] sat_relu(
    input logic signed [63:0] r,
    input int unsigned        data_w,
    input logic               relu
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] s;
    hi = (64'sd1 <<< (data_w - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) begin
      s = hi;
    end else if (r < lo) begin
      s = lo;
    end else begin
      s = r;
    end
    if (relu && (s < 64'sd0)) begin
      s = 64'sd0;
    end else begin
      s = s;
    end
    return s;
  endfunction

endpackage

// File: rtl/dense_mac_tree.sv
// ---------------------------------------------------------------------------
// dense_mac_tree
// Pipeline stage S1: masks inactive lanes, multiplies LANES signed pairs,
// sums them at full precision and registers the sum with a valid bit.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_accept   : a beat is being accepted this cycle
//   i_rem      : elements remaining before this beat (lane i active iff i<rem)
//   i_data     : packed signed activations, lane 0 in the LSBs
//   i_wgt      : packed signed weights, lane 0 in the LSBs
//   o_sum      : registered full-precision sum of products
//   o_valid    : o_sum holds the sum of a beat accepted on the previous edge
// ---------------------------------------------------------------------------
module dense_mac_tree
  import dense_pkg::*;
#(
  parameter int DATA_W = DENSE_DATA_W,
  parameter int LANES  = DENSE_LANES,
  parameter int LEN_W  = DENSE_LEN_W,
  parameter int SUM_W  = 2 * DENSE_DATA_W + $clog2(DENSE_LANES) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_accept,
  input  logic [LEN_W-1:0]           i_rem,
  input  logic [LANES*DATA_W-1:0]    i_data,
  input  logic [LANES*DATA_W-1:0]    i_wgt,
  output logic signed [SUM_W-1:0]    o_sum,
  output logic                       o_valid
);

  logic signed [DATA_W-1:0]   w_a [LANES];
  logic signed [DATA_W-1:0]   w_b [LANES];
  logic signed [2*DATA_W-1:0] w_p [LANES];
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [SUM_W-1:0]    r_sum;
  logic                       r_valid;

  // Lane masking, multipliers and adder tree (a zero weight kills a lane).
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_a[i] = i_data[i*DATA_W +: DATA_W];
      if (32'(i) < 32'(i_rem)) begin
        w_b[i] = i_wgt[i*DATA_W +: DATA_W];
      end else begin
        w_b[i] = '0;
      end
      w_p[i] = (2*DATA_W)'(w_a[i]) * (2*DATA_W)'(w_b[i]);
      w_sum  = w_sum + SUM_W'(w_p[i]);
    end
  end

  // S1 register: capture the beat sum; valid mirrors acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_accept;
      if (i_accept) begin
        r_sum <= w_sum;
      end else begin
        r_sum <= r_sum;
      end
    end
  end

  assign o_sum   = r_sum;
  assign o_valid = r_valid;

endmodule

// File: rtl/dense_accum.sv
// ---------------------------------------------------------------------------
// dense_accum
// Streaming fixed-point dot product: acc = bias<<FRAC + sum(data*wgt) over
// cfg_len elements, consumed LANES per beat, then result = sat(acc>>>FRAC)
// with optional ReLU, held until the consumer takes it.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, cfg_len,
//   bias, relu_en       : job start and its configuration (sampled in IDLE)
//   in_valid/in_ready   : input beat handshake; in_data/in_wgt packed lanes
//   out_valid/out_ready : result handshake; out_data saturated result
//   busy                : block is not idle
// ---------------------------------------------------------------------------
module dense_accum
  import dense_pkg::*;
#(
  parameter int DATA_W = DENSE_DATA_W,
  parameter int LANES  = DENSE_LANES,
  parameter int ACC_W  = DENSE_ACC_W,
  parameter int FRAC   = DENSE_FRAC,
  parameter int LEN_W  = DENSE_LEN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic signed [DATA_W-1:0]   bias,
  input  logic                       relu_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic [LANES*DATA_W-1:0]    in_wgt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       busy
);

  localparam int SUM_W = 2 * DATA_W + $clog2(LANES) + 1;
  localparam logic [LEN_W-1:0] LANES_L = LEN_W'(LANES);

  if (ACC_W < 2 * DATA_W + $clog2(LANES) + 4) begin : g_acc_w_check
    $error("dense_accum: ACC_W too narrow for DATA_W/LANES");
  end
  if (ACC_W > 64) begin : g_acc_w_max_check
    $error("dense_accum: ACC_W above 64 is not supported by sat_relu");
  end

  dense_state_e             r_state;
  dense_state_e             w_state_nxt;
  logic [LEN_W-1:0]         r_rem;
  logic [LEN_W-1:0]         w_rem_nxt;
  logic [LEN_W-1:0]         w_take;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_relu;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_busy;
  logic [DATA_W-1:0]        r_out_data;
  logic                     w_start;
  logic                     w_accept;
  logic                     w_last;
  logic [DATA_W-1:0]        w_res_acc;
  logic [DATA_W-1:0]        w_res_bias;
  logic signed [SUM_W-1:0]  w_s1_sum;
  logic                     w_s1_valid;

  dense_mac_tree #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .LEN_W  (LEN_W),
    .SUM_W  (SUM_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_rem    (r_rem),
    .i_data   (in_data),
    .i_wgt    (in_wgt),
    .o_sum    (w_s1_sum),
    .o_valid  (w_s1_valid)
  );

  // Handshake decode, remaining-count update and result formatting.
  always_comb begin
    w_start    = (r_state == ST_IDLE) && start;
    w_accept   = in_valid && r_in_ready;
    w_take     = (r_rem > LANES_L) ? LANES_L : r_rem;
    w_last     = (r_rem <= LANES_L);
    // With N=0 the loaded acc is bias<<FRAC, so the result is just bias.
    w_res_bias = DATA_W'(sat_relu(64'(bias), 32'(DATA_W), relu_en));
    w_res_acc  = DATA_W'(sat_relu(64'(r_acc >>> FRAC), 32'(DATA_W), r_relu));
    if (w_start) begin
      w_rem_nxt = cfg_len;
    end else if (w_accept) begin
      w_rem_nxt = r_rem - w_take;
    end else begin
      w_rem_nxt = r_rem;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (cfg_len == '0) ? ST_OUT : ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // S1 empty means the final product has already landed in acc.
        if (!w_s1_valid) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_OUT: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers; handshake outputs are registered from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem       <= '0;
      r_acc       <= '0;
      r_relu      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_rem       <= w_rem_nxt;
      r_in_ready  <= (w_state_nxt == ST_RUN) && (w_rem_nxt != '0);
      r_out_valid <= (w_state_nxt == ST_OUT);
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_start) begin
        r_acc  <= ACC_W'(bias) <<< FRAC;
        r_relu <= relu_en;
      end else if (w_s1_valid) begin
        r_acc  <= r_acc + ACC_W'(w_s1_sum);
        r_relu <= r_relu;
      end else begin
        r_acc  <= r_acc;
        r_relu <= r_relu;
      end
      if (w_start && (cfg_len == '0)) begin
        r_out_data <= w_res_bias;
      end else if ((r_state == ST_DRAIN) && !w_s1_valid) begin
        r_out_data <= w_res_acc;
      end else begin
        r_out_data <= r_out_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dense_accum.sv
// ---------------------------------------------------------------------------
// tb_dense_accum
// Directed and randomized jobs against a plain-arithmetic dot-product model.
// ---------------------------------------------------------------------------
module tb_dense_accum;

  localparam int DW = 16;
  localparam int LN = 9;
  localparam int AW = 40;
  localparam int FR = 8;
  localparam int LW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [LW-1:0]        cfg_len;
  logic signed [DW-1:0] bias;
  logic                 relu_en;
  logic                 in_valid;
  logic                 in_ready;
  logic [LN*DW-1:0]     in_data;
  logic [LN*DW-1:0]     in_wgt;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  logic signed [DW-1:0] ed [0:63];
  logic signed [DW-1:0] ew [0:63];
  bit                   junk_max = 1'b0;
  logic [DW-1:0]        last_out;

  dense_accum #(
    .DATA_W (DW),
    .LANES  (LN),
    .ACC_W  (AW),
    .FRAC   (FR),
    .LEN_W  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .bias      (bias),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_wgt    (in_wgt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bias*2^FRAC plus the first n products, floor-shifted, clamped.
  function automatic logic [DW-1:0] model(input int n, input logic signed [DW-1:0] b, input bit relu);
    longint acc;
    longint r;
    acc = longint'(b) * 64'sd256;
    for (int j = 0; j < n; j++) acc += longint'(ed[j]) * longint'(ew[j]);
    r = acc >>> FR;
    if (r > 64'sd32767) r = 64'sd32767;
    else if (r < -64'sd32768) r = -64'sd32768;
    if (relu && r < 64'sd0) r = 64'sd0;
    return r[DW-1:0];
  endfunction

  // Pack beat k; positions at or beyond n carry junk the DUT must ignore.
  function automatic logic [LN*DW-1:0] pack(input int n, input int k, input bit wsel);
    logic [LN*DW-1:0] p;
    logic [DW-1:0]    v;
    int               idx;
    p = '0;
    for (int i = 0; i < LN; i++) begin
      idx = k * LN + i;
      if (idx < n) v = wsel ? ew[idx] : ed[idx];
      else v = junk_max ? 16'h7FFF : 16'($urandom);
      p[i*DW +: DW] = v;
    end
    return p;
  endfunction

  task automatic fill_const(input logic [DW-1:0] d, input logic [DW-1:0] w);
    for (int j = 0; j < 64; j++) begin
      ed[j] = d;
      ew[j] = w;
    end
  endtask

  task automatic fill_rand(input int mode);
    for (int j = 0; j < 64; j++) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)) begin
        ed[j] = 16'($urandom);
        ew[j] = 16'($urandom);
      end else begin
        ed[j] = 16'(int'($urandom_range(0, 1023)) - 512);
        ew[j] = 16'(int'($urandom_range(0, 1023)) - 512);
      end
    end
  endtask

  task automatic do_job(input int n, input logic signed [DW-1:0] b, input bit relu,
                        input bit gaps, input int hold, input bit poke, input string tag);
    logic [DW-1:0] exp;
    int            nb;
    int            cnt;
    exp     = model(n, b, relu);
    cfg_len = LW'(n);
    bias    = b;
    relu_en = relu;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    cfg_len = 16'($urandom);
    bias    = 16'($urandom);
    relu_en = 1'($urandom);
    if (n == 0) begin
      chk({tag, "/n0_valid"}, 64'(out_valid), 64'd1);
    end else begin
      nb = (n + LN - 1) / LN;
      for (int k = 0; k < nb; k++) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          in_data  = (LN*DW)'({5{$urandom}});
          in_wgt   = (LN*DW)'({5{$urandom}});
          tick;
        end
        in_valid = 1'b1;
        in_data  = pack(n, k, 1'b0);
        in_wgt   = pack(n, k, 1'b1);
        cnt = 0;
        while (in_ready !== 1'b1 && cnt < 20) begin
          tick;
          cnt++;
        end
        if (cnt >= 20) chk({tag, "/ready_timeout"}, 64'(in_ready), 64'd1);
        else if (!gaps) chk({tag, "/full_rate"}, 64'(cnt), 64'd0);
        tick;
      end
      in_valid = 1'b0;
      in_data  = (LN*DW)'({5{$urandom}});
      chk({tag, "/lat0"}, 64'(out_valid), 64'd0);
      tick;
      chk({tag, "/lat1"}, 64'(out_valid), 64'd0);
      tick;
      chk({tag, "/lat2"}, 64'(out_valid), 64'd1);
    end
    chk({tag, "/data"}, 64'(out_data), 64'(exp));
    last_out = out_data;
    chk({tag, "/busy_out"}, 64'(busy), 64'd1);
    chk({tag, "/rdy_out"}, 64'(in_ready), 64'd0);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        start   = 1'b1;
        cfg_len = '0;
        bias    = 16'sh1234;
        relu_en = 1'b0;
      end
      tick;
      start = 1'b0;
      chk({tag, "/held_data"}, 64'(out_data), 64'(exp));
      chk({tag, "/held_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "/held_rdy"}, 64'(in_ready), 64'd0);
      chk({tag, "/held_busy"}, 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    start     = poke;
    cfg_len   = '0;
    tick;
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "/done_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "/done_busy"}, 64'(busy), 64'd0);
    if (poke) begin
      tick;
      chk({tag, "/start_ignored"}, 64'({busy, out_valid}), 64'd0);
    end
  endtask

  initial begin
    int                   n;
    logic signed [DW-1:0] b;
    rst       = 1'b1;
    start     = 1'b0;
    cfg_len   = '0;
    bias      = '0;
    relu_en   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_wgt    = '0;
    out_ready = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // One full beat of 1.0*1.0.
    fill_const(16'h0100, 16'h0100);
    do_job(9, 16'sh0000, 1'b0, 1'b0, 0, 1'b0, "n9_unit");
    chk("n9_unit_lit", 64'(last_out), 64'h0900);

    // Partial last beat with large junk in the inactive lanes.
    junk_max = 1'b1;
    do_job(20, 16'sh0000, 1'b0, 1'b0, 1, 1'b0, "n20_mask");
    chk("n20_mask_lit", 64'(last_out), 64'h1400);
    junk_max = 1'b0;

    // Saturation both ways, then ReLU on the negative case.
    fill_const(16'h7FFF, 16'h7FFF);
    do_job(9, 16'sh0000, 1'b0, 1'b0, 0, 1'b0, "sat_pos");
    chk("sat_pos_lit", 64'(last_out), 64'h7FFF);
    fill_const(16'h7FFF, 16'h8001);
    do_job(9, 16'sh0000, 1'b0, 1'b0, 0, 1'b0, "sat_neg");
    chk("sat_neg_lit", 64'(last_out), 64'h8000);
    do_job(9, 16'sh0000, 1'b1, 1'b0, 0, 1'b0, "sat_relu");
    chk("sat_relu_lit", 64'(last_out), 64'h0000);

    // Empty vectors: result is the bias itself.
    do_job(0, 16'sh0180, 1'b0, 1'b0, 0, 1'b0, "n0_bias");
    chk("n0_bias_lit", 64'(last_out), 64'h0180);
    do_job(0, -16'sh0100, 1'b1, 1'b0, 0, 1'b0, "n0_relu");
    chk("n0_relu_lit", 64'(last_out), 64'h0000);

    // Stalled consumer with start pulses that must be ignored.
    fill_const(16'h0100, 16'h0100);
    do_job(9, 16'sh0000, 1'b0, 1'b0, 5, 1'b1, "hold5");

    // Reset in the middle of a three-beat job.
    cfg_len = LW'(27);
    bias    = 16'sh0100;
    relu_en = 1'b0;
    start   = 1'b1;
    tick;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = pack(27, 0, 1'b0);
    in_wgt   = pack(27, 0, 1'b1);
    tick;
    in_valid = 1'b0;
    rst      = 1'b1;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("midrst_quiet", 64'({out_valid, busy, in_ready}), 64'd0);
      tick;
    end
    do_job(9, 16'sh0000, 1'b0, 1'b0, 0, 1'b0, "after_rst");
    chk("after_rst_lit", 64'(last_out), 64'h0900);

    // Randomized jobs against the model.
    for (int j = 0; j < 14; j++) begin
      if (j == 0) n = 1;
      else if (j == 1) n = 18;
      else if (j == 2) n = 10;
      else n = int'($urandom_range(0, 40));
      fill_rand(j % 3);
      b = 16'($urandom);
      do_job(n, b, 1'($urandom_range(0, 1)), 1'(j % 2), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $sformatf("rand%0d_n%0d", j, n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
